// File: rtl/colormap_engine_if.sv
// Valid/ready stream bundle used on both sides of the colour mapper.
interface colormap_engine_if #(
  parameter int W = 16
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/colormap_engine.sv
// Streaming iteration-count to RGB565 mapper: writable palette RAM,
// per-frame palette rotation and wrap/mirror indexing, 2-stage pipeline.
module colormap_engine #(
  parameter int ITER_W  = 16,
  parameter int PAL_AW  = 8,
  parameter int COLOR_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  colormap_engine_if.slave    s,
  input  logic [ITER_W-1:0]   max_iter,
  input  logic                mode,
  input  logic [COLOR_W-1:0]  interior_color,
  input  logic                frame_tick,
  input  logic [PAL_AW-1:0]   cycle_step,
  input  logic                pal_we,
  input  logic [PAL_AW-1:0]   pal_waddr,
  input  logic [COLOR_W-1:0]  pal_wdata,
  colormap_engine_if.master   m,
  output logic [PAL_AW:0]     offset
);

  logic               en;
  logic [PAL_AW:0]    raw;
  logic [PAL_AW-1:0]  idx_next;

  logic               v1;
  logic               int1;
  logic [PAL_AW-1:0]  idx1;

  logic [COLOR_W-1:0] pal [2**PAL_AW];

  // Pipeline enable and rotated/mirrored palette index for the incoming pixel
  always_comb begin
    en       = !m.valid || m.ready;
    s.ready  = en;
    raw      = s.data[PAL_AW:0] + offset;
    idx_next = raw[PAL_AW-1:0];
    if (mode && raw[PAL_AW]) begin
      idx_next = ~raw[PAL_AW-1:0];
    end
  end

  // Rotation offset advances once per frame, regardless of stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset <= '0;
    end else if (frame_tick) begin
      offset <= offset + {1'b0, cycle_step};
    end
  end

  // Stage 1: capture valid, interior flag and palette index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      int1 <= 1'b0;
      idx1 <= '0;
    end else if (en) begin
      v1   <= s.valid;
      int1 <= (s.data >= max_iter);
      idx1 <= idx_next;
    end
  end

  // Palette write port; not reset, read-first against the stage-2 read
  always_ff @(posedge clk) begin
    if (pal_we) begin
      pal[pal_waddr] <= pal_wdata;
    end
  end

  // Stage 2: synchronous palette read and interior substitution
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m.valid <= 1'b0;
      m.data  <= '0;
    end else if (en) begin
      m.valid <= v1;
      if (v1) begin
        m.data <= int1 ? interior_color : pal[idx1];
      end
    end
  end

endmodule

// File: tb/tb_colormap_engine.sv
// Scoreboard bench for colormap_engine.
module tb_colormap_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] max_iter;
  logic        mode;
  logic [15:0] interior_color;
  logic        frame_tick;
  logic [7:0]  cycle_step;
  logic        pal_we;
  logic [7:0]  pal_waddr;
  logic [15:0] pal_wdata;
  logic [8:0]  offset;

  colormap_engine_if #(.W(16)) s_if ();
  colormap_engine_if #(.W(16)) m_if ();

  colormap_engine #(.ITER_W(16), .PAL_AW(8), .COLOR_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .s              (s_if.slave),
    .max_iter       (max_iter),
    .mode           (mode),
    .interior_color (interior_color),
    .frame_tick     (frame_tick),
    .cycle_step     (cycle_step),
    .pal_we         (pal_we),
    .pal_waddr      (pal_waddr),
    .pal_wdata      (pal_wdata),
    .m              (m_if.master),
    .offset         (offset)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [15:0] pal_m [256];
  logic [8:0]  off_m = '0;
  logic [15:0] exp_q [$];
  int          acc_q [$];
  bit          rand_ready = 0;
  bit          ready_fix = 1;
  bit          chk_lat = 0;
  bit          hold_prev = 0;
  logic [15:0] prev_rgb = '0;
  int          last_acc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_of(input logic [15:0] it);
    logic [8:0] raw;
    logic [7:0] idx;
    if (it >= max_iter) return interior_color;
    raw = 9'(it[8:0] + off_m);
    idx = raw[7:0];
    if (mode && raw[8]) idx = ~raw[7:0];
    return pal_m[idx];
  endfunction

  always @(posedge clk) cyc++;

  // Downstream ready: fixed or random, changed just after each edge
  initial begin
    m_if.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_if.ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
    end
  end

  // Output monitor: scoreboard pop, latency and hold-stability checks
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", 32'(m_if.valid), 32'd1);
        check("hold_rgb", 32'(m_if.data), 32'(prev_rgb));
      end
      hold_prev = m_if.valid && !m_if.ready;
      prev_rgb  = m_if.data;
      if (m_if.valid && m_if.ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(m_if.data), 32'hDEAD_BEEF);
        end else begin
          check("rgb", 32'(m_if.data), 32'(exp_q.pop_front()));
          if (chk_lat) check("latency", 32'(cyc - acc_q[0]), 32'd2);
          void'(acc_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [15:0] it);
    bit done = 0;
    s_if.valid = 1'b1;
    s_if.data  = it;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (s_if.ready) begin
        exp_q.push_back(exp_of(it));
        acc_q.push_back(cyc);
        last_acc = cyc;
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    s_if.valid = 1'b0;
    for (int n = 0; n < 500 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic tick(input logic [7:0] step);
    s_if.valid = 1'b0;
    cycle_step = step;
    frame_tick = 1'b1;
    @(posedge clk);
    off_m = 9'(off_m + {1'b0, step});
    #1;
    frame_tick = 1'b0;
    check("offset", 32'(offset), 32'(off_m));
  endtask

  task automatic load_pal(input bit rnd);
    s_if.valid = 1'b0;
    for (int i = 0; i < 256; i++) begin
      pal_we    = 1'b1;
      pal_waddr = 8'(i);
      pal_wdata = rnd ? 16'($urandom) : 16'(i);
      pal_m[i]  = pal_wdata;
      @(posedge clk);
      #1;
    end
    pal_we = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_first;
    logic [15:0] tv [5];
    rst = 1'b1;
    s_if.valid = 1'b0; s_if.data = '0;
    max_iter = 16'hFFFF; mode = 1'b0; interior_color = 16'hF81F;
    frame_tick = 1'b0; cycle_step = '0;
    pal_we = 1'b0; pal_waddr = '0; pal_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(m_if.valid), 32'd0);
    check("rst_rgb", 32'(m_if.data), 32'd0);
    check("rst_offset", 32'(offset), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: identity palette, streaming 0..300 back to back
    load_pal(0);
    chk_lat = 1;
    t_first = cyc;
    for (int i = 0; i <= 300; i++) begin
      send(16'(i));
      if (i == 0) t_first = last_acc;
    end
    drain();
    check("t1_throughput", 32'(last_acc - t_first), 32'd300);

    // 2: interior threshold
    max_iter = 16'd100;
    tv[0] = 16'd99; tv[1] = 16'd100; tv[2] = 16'd4000;
    for (int i = 0; i < 3; i++) send(tv[i]);
    drain();
    max_iter = 16'hFFFF;

    // 3: mirror indexing
    mode = 1'b1;
    tv[0] = 16'd255; tv[1] = 16'd256; tv[2] = 16'd257; tv[3] = 16'd511; tv[4] = 16'd512;
    for (int i = 0; i < 5; i++) send(tv[i]);
    drain();
    mode = 1'b0;

    // 4: rotation and offset wrap
    tick(8'd3);
    tick(8'd3);
    send(16'd254);
    drain();
    tick(8'd255);
    tick(8'd249);
    check("offset_510", 32'(offset), 32'd510);
    tick(8'd3);
    check("offset_wrap", 32'(offset), 32'd1);
    chk_lat = 0;

    // 5: random backpressure, random palette, mixed modes and ticks
    load_pal(1);
    max_iter = 16'd1500;
    rand_ready = 1;
    for (int k = 0; k < 1000; k++) begin
      if (k % 250 == 0) begin
        s_if.valid = 1'b0;
        mode = ~mode;
        @(posedge clk); #1;
      end
      send(16'($urandom_range(0, 2047)));
      if ($urandom_range(0, 39) == 0) tick(8'($urandom));
    end
    rand_ready = 0;
    drain();
    max_iter = 16'hFFFF;
    mode = 1'b0;

    // Reset mid-stream with pixels in both stages
    ready_fix = 0;
    repeat (2) @(posedge clk); #1;
    send(16'd10);
    send(16'd11);
    s_if.valid = 1'b0;
    check("stalled_valid", 32'(m_if.valid), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(m_if.valid), 32'd0);
    check("midrst_offset", 32'(offset), 32'd0);
    exp_q.delete();
    acc_q.delete();
    off_m = '0;
    ready_fix = 1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(s_if.ready), 32'd1);
    @(posedge clk); #1;

    // 6: palette write colliding with the stage-2 read of the same index
    send(16'd5);
    pal_we = 1'b1; pal_waddr = 8'd5; pal_wdata = 16'hAAAA;
    pal_m[5] = 16'hAAAA;
    send(16'd5);
    pal_we = 1'b0;
    send(16'd5);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
